// File: rtl/tray_current_driver.sv
// Tray current driver: ramps the motor drive level toward the commanded current.
// Optional soft-start stepping is enabled by defining TRAY_SOFT_START_EN.
module tray_current_driver #(
  parameter int RAMP_DIV      = 64,
  parameter int SETTLE_CYCLES = 256,
  parameter int PWM_PRESCALE  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] action,
  input  logic [3:0] aicou,
  input  logic [1:0] main_station,
  output logic       pwm_out,
  output logic [3:0] cur_level,
  output logic       drv_busy,
  output logic       done,
  output logic       abort,
  output logic       cmd_err
);

  typedef enum logic [1:0] {
    IDLE,
    RAMP,
    SETTLE,
    DONE
  } state_t;

  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int PW = (PWM_PRESCALE > 1) ? $clog2(PWM_PRESCALE) : 1;
  localparam logic [SW-1:0] SET_MAX = SW'(SETTLE_CYCLES - 1);
  localparam logic [SW-1:0] SET_ONE = SW'(1);
  localparam logic [PW-1:0] PRE_MAX = PW'(PWM_PRESCALE - 1);
  localparam logic [PW-1:0] PRE_ONE = PW'(1);

  if (RAMP_DIV < 1 || SETTLE_CYCLES < 1 || PWM_PRESCALE < 1) begin : g_bad_cfg
    $error("tray_current_driver: parameters must be >= 1");
  end

  state_t        r_state;
  state_t        w_state_nxt;
  logic [3:0]    r_level;
  logic [3:0]    w_level_nxt;
  logic [3:0]    r_target;
  logic [3:0]    w_target_nxt;
  logic [SW-1:0] r_set;
  logic [SW-1:0] w_set_nxt;
  logic          r_err;
  logic          w_err_nxt;
  logic          r_abort;
  logic          w_abort_nxt;
  logic          w_pwr_on;
  logic          w_acc;

`ifdef TRAY_SOFT_START_EN
  localparam int RW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [RW-1:0] RAMP_MAX = RW'(RAMP_DIV - 1);
  localparam logic [RW-1:0] RAMP_ONE = RW'(1);

  logic [RW-1:0] r_ramp;
  logic [RW-1:0] w_ramp_nxt;
  logic [3:0]    w_step;

  assign w_step = (r_level < r_target) ? r_level + 4'd1 : r_level - 4'd1;
`endif

  logic [PW-1:0] r_pre;
  logic [3:0]    r_pwm_cnt;
  logic          r_pwm;

  assign w_pwr_on  = (main_station == 2'b11);
  assign cmd_ready = (r_state == IDLE) && !w_pwr_on;
  assign w_acc     = cmd_valid && cmd_ready;
  assign drv_busy  = (r_state != IDLE);
  assign done      = (r_state == DONE);
  assign cmd_err   = done && r_err;
  assign abort     = r_abort;
  assign cur_level = r_level;
  assign pwm_out   = r_pwm;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_level_nxt  = r_level;
    w_target_nxt = r_target;
    w_set_nxt    = '0;
    w_err_nxt    = r_err;
    w_abort_nxt  = 1'b0;
`ifdef TRAY_SOFT_START_EN
    w_ramp_nxt   = '0;
`endif
    if (w_pwr_on) begin
      // Power on kills any command; only a busy driver reports it.
      w_state_nxt  = IDLE;
      w_level_nxt  = 4'd0;
      w_target_nxt = 4'd0;
      w_err_nxt    = 1'b0;
      w_abort_nxt  = drv_busy;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_acc) begin
            unique case (1'b1)
              (action == 2'b01): begin
                w_target_nxt = aicou;
                w_err_nxt    = 1'b0;
                w_state_nxt  = RAMP;
              end
              (action == 2'b00): begin
                w_target_nxt = 4'd0;
                w_err_nxt    = 1'b0;
                w_state_nxt  = RAMP;
              end
              default: begin
                w_err_nxt    = 1'b1;
                w_state_nxt  = DONE;
              end
            endcase
          end
        end
        RAMP: begin
`ifdef TRAY_SOFT_START_EN
          if (r_level == r_target) begin
            w_state_nxt = SETTLE;
          end else if (r_ramp == RAMP_MAX) begin
            w_level_nxt = w_step;
            if (w_step == r_target) w_state_nxt = SETTLE;
          end else begin
            w_ramp_nxt = r_ramp + RAMP_ONE;
          end
`else
          w_level_nxt = r_target;
          w_state_nxt = SETTLE;
`endif
        end
        SETTLE: begin
          if (r_set == SET_MAX) w_state_nxt = DONE;
          else                  w_set_nxt   = r_set + SET_ONE;
        end
        DONE: begin
          w_state_nxt = IDLE;
        end
        default: begin
          w_state_nxt = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_level  <= 4'd0;
      r_target <= 4'd0;
      r_set    <= '0;
      r_err    <= 1'b0;
      r_abort  <= 1'b0;
`ifdef TRAY_SOFT_START_EN
      r_ramp   <= '0;
`endif
    end else begin
      r_level  <= w_level_nxt;
      r_target <= w_target_nxt;
      r_set    <= w_set_nxt;
      r_err    <= w_err_nxt;
      r_abort  <= w_abort_nxt;
`ifdef TRAY_SOFT_START_EN
      r_ramp   <= w_ramp_nxt;
`endif
    end
  end

  // PWM timebase free-runs; level 0 keeps the pad low, 15 gives 15/16.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre     <= '0;
      r_pwm_cnt <= 4'd0;
      r_pwm     <= 1'b0;
    end else begin
      if (r_pre == PRE_MAX) begin
        r_pre     <= '0;
        r_pwm_cnt <= r_pwm_cnt + 4'd1;
      end else begin
        r_pre     <= r_pre + PRE_ONE;
      end
      r_pwm <= (r_pwm_cnt < r_level);
    end
  end

endmodule

// File: tb/tb_tray_current_driver.sv
// Directed bench for tray_current_driver (RAMP_DIV=4, SETTLE=8, PRESCALE=1).
// Expectations follow TRAY_SOFT_START_EN when it is defined for the build.
module tb_tray_current_driver;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] action;
  logic [3:0] aicou;
  logic [1:0] main_station;
  logic       pwm_out;
  logic [3:0] cur_level;
  logic       drv_busy;
  logic       done;
  logic       abort;
  logic       cmd_err;

  int n_cmp = 0;
  int n_err = 0;

  tray_current_driver #(
    .RAMP_DIV     (4),
    .SETTLE_CYCLES(8),
    .PWM_PRESCALE (1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .action      (action),
    .aicou       (aicou),
    .main_station(main_station),
    .pwm_out     (pwm_out),
    .cur_level   (cur_level),
    .drv_busy    (drv_busy),
    .done        (done),
    .abort       (abort),
    .cmd_err     (cmd_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_cmd(input logic [1:0] act, input logic [3:0] lvl);
    action    = act;
    aicou     = lvl;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  // Cycles from the accept edge to the edge that enters DONE.
  function automatic int cmd_len(input int steps);
`ifdef TRAY_SOFT_START_EN
    return ((steps == 0) ? 1 : steps * 4) + 8;
`else
    return 1 + 8;
`endif
  endfunction

  task automatic wait_done(input string tag, input int exp, output bit rdy);
    int n;
    rdy = 1'b0;
    for (n = 1; n <= 300; n++) begin
      tick();
      if (cmd_ready) rdy = 1'b1;
      if (done) break;
    end
    chk(tag, n, exp);
  endtask

  task automatic pwm_highs(output int hi);
    hi = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      hi += int'(pwm_out);
    end
  endtask

  initial begin
    bit rdy;
    int hi;
    rst_n        = 1'b0;
    cmd_valid    = 1'b0;
    action       = 2'b00;
    aicou        = 4'd0;
    main_station = 2'b11;
    repeat (3) tick();
    chk("rst_ready", cmd_ready, 0);
    chk("rst_level", cur_level, 0);
    chk("rst_busy", drv_busy, 0);
    chk("rst_pulses", {done, abort, cmd_err, pwm_out}, 0);
    rst_n = 1'b1;
    tick();
    chk("pwron_ready", cmd_ready, 0);
    main_station = 2'b01;
    tick();
    chk("idle_ready", cmd_ready, 1);

    do_cmd(2'b01, 4'd8);
    chk("up_busy", drv_busy, 1);
    chk("up_ready", cmd_ready, 0);
`ifdef TRAY_SOFT_START_EN
    repeat (3) tick();
    chk("up_hold", cur_level, 0);
    tick();
    chk("up_step1", cur_level, 1);
    for (int k = 2; k <= 8; k++) begin
      repeat (4) tick();
      chk($sformatf("up_step%0d", k), cur_level, k);
    end
`else
    tick();
    chk("up_jump", cur_level, 8);
`endif
    repeat (7) tick();
    chk("up_settle", done, 0);
    chk("up_settle_busy", drv_busy, 1);
    tick();
    chk("up_done", done, 1);
    chk("up_done_err", cmd_err, 0);
    tick();
    chk("up_done_once", done, 0);
    chk("up_idle", drv_busy, 0);
    pwm_highs(hi);
    chk("pwm_8of16", hi, 8);

    do_cmd(2'b00, 4'd9);
    wait_done("down_len", cmd_len(8), rdy);
    chk("down_level", cur_level, 0);
    tick();
    pwm_highs(hi);
    chk("pwm_0of16", hi, 0);

    do_cmd(2'b01, 4'd6);
    cmd_valid = 1'b1;
    action    = 2'b01;
    aicou     = 4'd3;
    wait_done("hold_len", cmd_len(6), rdy);
    chk("hold_no_ready", rdy, 0);
    chk("hold_level", cur_level, 6);
    tick();
    chk("hold_ready", cmd_ready, 1);
    tick();
    chk("hold_accept", drv_busy, 1);
    cmd_valid = 1'b0;
    wait_done("hold_len2", cmd_len(3), rdy);
    chk("hold_level2", cur_level, 3);
    tick();

    do_cmd(2'b10, 4'd12);
    chk("rsv_done", done, 1);
    chk("rsv_err", cmd_err, 1);
    chk("rsv_level", cur_level, 3);
    tick();
    chk("rsv_clear", {done, cmd_err, drv_busy}, 0);
    chk("rsv_level2", cur_level, 3);

    do_cmd(2'b01, 4'd3);
    wait_done("eq_len", cmd_len(0), rdy);
    chk("eq_err", cmd_err, 0);
    chk("eq_level", cur_level, 3);
    tick();

    do_cmd(2'b01, 4'd9);
`ifdef TRAY_SOFT_START_EN
    repeat (8) tick();
    chk("mid_level", cur_level, 5);
`else
    tick();
    chk("mid_level", cur_level, 9);
`endif
    main_station = 2'b11;
    tick();
    chk("pwr_level", cur_level, 0);
    chk("pwr_abort", abort, 1);
    chk("pwr_busy", drv_busy, 0);
    chk("pwr_ready", cmd_ready, 0);
    chk("pwr_done", done, 0);
    tick();
    chk("pwr_abort_once", abort, 0);
    tick();
    chk("pwr_abort_held", abort, 0);
    chk("pwr_ready_held", cmd_ready, 0);
    main_station = 2'b01;
    tick();
    chk("pwr_release", cmd_ready, 1);

    cmd_valid    = 1'b1;
    action       = 2'b01;
    aicou        = 4'd7;
    main_station = 2'b11;
    tick();
    chk("race_busy", drv_busy, 0);
    chk("race_abort", abort, 0);
    chk("race_level", cur_level, 0);
    cmd_valid    = 1'b0;
    main_station = 2'b01;
    tick();

    do_cmd(2'b01, 4'd15);
    repeat (5) tick();
    chk("rstmid_busy_pre", drv_busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid_level", cur_level, 0);
    chk("rstmid_outs", {drv_busy, done, abort, cmd_err, pwm_out}, 0);
    repeat (2) tick();
    chk("rstmid_quiet", {done, abort}, 0);
    rst_n = 1'b1;
    tick();
    chk("rstmid_ready", cmd_ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
